// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// and presents a registered difference and borrow-out with a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow,
    output logic             dbg_state
);

    // Handshake: start is a request that is accepted on any rising edge where the
    // block is not busy (including the done cycle); requests while busy are dropped,
    // never queued. done is a single-cycle strobe qualifying difference/borrow,
    // which otherwise hold their last completed value.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;

    logic             w_a0;
    logic             w_b0;
    logic             w_d;
    logic             w_br_next;
    logic             w_last;

    assign w_a0      = r_a[0];
    assign w_b0      = r_b[0];
    assign w_d       = w_a0 ^ w_b0 ^ r_br;
    assign w_br_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_br       <= 1'b0;
            r_cnt      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            difference <= '0;
            borrow     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // Result fills from the MSB side so bit 0 lands at the LSB after WIDTH shifts.
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_res <= {w_d, r_res[WIDTH-1:1]};
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        difference <= {w_d, r_res[WIDTH-1:1]};
                        borrow     <= w_br_next;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed vectors with
// hand-computed results, checked by an independent done-driven monitor.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] difference;
    logic         borrow;
    logic         dbg_state;

    logic [W:0]   exp_q[$];
    int           total;
    int           bad;
    logic [W-1:0] hold_d;
    logic         hold_br;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .difference (difference),
        .borrow     (borrow),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("result", {23'd0, borrow, difference}, {23'd0, e});
            end
        end
    end

    // One operation with full latency/hold checks; repulse re-asserts start at E3.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] ed, input logic eb, input bit repulse);
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        exp_q.push_back({eb, ed});
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            check("busy_run", {31'd0, busy}, 32'd1);
            check("done_run", {31'd0, done}, 32'd0);
            check("state_run", {31'd0, dbg_state}, 32'd1);
            check("diff_hold", {23'd0, borrow, difference}, {23'd0, hold_br, hold_d});
            if (repulse && k == 2) begin
                start = 1'b1;
                a = 8'h01;
                b = 8'h02;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("done_at_E8", {31'd0, done}, 32'd1);
        check("busy_at_E8", {31'd0, busy}, 32'd0);
        hold_d  = ed;
        hold_br = eb;
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_after", {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] ed;
        logic         eb;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   done_cyc[$];
        int   cyc;

        total = 0;
        bad = 0;
        hold_d = '0;
        hold_br = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        rst_n = 1'b0;

        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, difference}, 32'd0);
        check("rst_borrow", {31'd0, borrow}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 8'h01, 8'hFE, 1'b0};
        vecs[4] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[5] = '{8'hA5, 8'h5A, 8'h4B, 1'b0};
        foreach (vecs[i]) run_op(vecs[i].va, vecs[i].vb, vecs[i].ed, vecs[i].eb, 1'b0);

        // re-pulsed start during RUN is ignored
        run_op(8'h40, 8'h11, 8'h2F, 1'b0, 1'b1);

        // start held high: back-to-back every W+1 cycles
        @(negedge clk);
        a = 8'h80;
        b = 8'h01;
        start = 1'b1;
        repeat (3) exp_q.push_back({1'b0, 8'h7F});
        cyc = 0;
        while (done_cyc.size() < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done) done_cyc.push_back(cyc);
        end
        start = 1'b0;
        check("b2b_count", done_cyc.size(), 32'd3);
        if (done_cyc.size() == 3) begin
            check("b2b_first", done_cyc[0], 32'd9);
            check("b2b_gap1", done_cyc[1] - done_cyc[0], 32'd9);
            check("b2b_gap2", done_cyc[2] - done_cyc[1], 32'd9);
        end
        repeat (2) @(negedge clk);
        check("b2b_idle", {31'd0, busy}, 32'd0);

        // reset at E4 aborts the operation with no done pulse
        @(negedge clk);
        a = 8'h33;
        b = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_diff", {24'd0, difference}, 32'd0);
        check("abort_borrow", {31'd0, borrow}, 32'd0);
        check("abort_state", {31'd0, dbg_state}, 32'd0);
        hold_d = '0;
        hold_br = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_done", {31'd0, busy | done}, 32'd0);
        run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        check("timeout", 32'd1, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide: reset, asynchronous and active-low.
REQ-004 Port start SHALL be an input, 1 bit wide: request to begin a subtraction; sampled on each rising clk edge.
REQ-005 Port a SHALL be an input, WIDTH bits wide: the minuend, sampled only on the accepting edge.
REQ-006 Port b SHALL be an input, WIDTH bits wide: the subtrahend, sampled only on the accepting edge.
REQ-007 Port busy SHALL be an output, 1 bit wide: high while an operation is in progress.
REQ-008 Port done SHALL be an output, 1 bit wide: a one-cycle pulse marking that the result is valid.
REQ-009 Port difference SHALL be an output, WIDTH bits wide: the registered result a - b, modulo 2^WIDTH.
REQ-010 Port borrow SHALL be an output, 1 bit wide: the registered borrow-out, high when a < b (unsigned).

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and RUN, and all outputs SHALL be registered.
REQ-012 IDLE with start=1 at an edge (E0) SHALL perform all of the following on E0:
- accept the request;
- load a and b into internal shift registers;
- clear the internal borrow flop and the bit counter;
- enter RUN and set busy=1.
REQ-013 IDLE with start=0 SHALL remain in IDLE with all outputs holding.
REQ-014 In RUN, each edge SHALL process one bit, LSB first.
- Each RUN edge SHALL compute d = a_i XOR b_i XOR br.
- Each RUN edge SHALL compute br_next = (NOT a_i AND b_i) OR (NOT(a_i XOR b_i) AND br).
- Each RUN edge SHALL shift d into the result register from the MSB side and shift the operand registers right by one.
REQ-015 Bit i SHALL be processed on edge E(i+1), so the last bit is processed on edge E(WIDTH).
REQ-016 On edge E(WIDTH) the block SHALL do all of the following:
- load the complete result into difference and the final br_next into borrow;
- set done=1 and busy=0;
- return to IDLE.
REQ-017 Latency SHALL be fixed at WIDTH cycles from the accepting edge to done, independent of operand values.
REQ-018 done SHALL be high for exactly one cycle and SHALL clear on the next edge.
REQ-019 difference and borrow SHALL hold their values until the next completion; they SHALL NOT change on start or during RUN.
REQ-020 start asserted while in RUN SHALL be ignored and SHALL NOT be queued.
- Changes on a and b during RUN SHALL NOT affect the result.
REQ-021 start high in the cycle where done=1 SHALL be accepted on that edge; back-to-back operations SHALL therefore complete every WIDTH+1 cycles.
REQ-022 Intermediate partial results SHALL NOT appear on difference.

Reset
REQ-023 Assertion of rst_n=0 SHALL immediately, without waiting for clk, force all of the following:
- state to IDLE;
- busy=0, done=0;
- difference to all zeros, borrow=0;
- the internal shift registers, counter and borrow flop to zero.
REQ-024 Reset mid-operation SHALL abort the operation.
- No done pulse SHALL be issued for the aborted operation.
- The first start accepted after release SHALL execute normally.
REQ-025 On the first edge with rst_n=1 the block SHALL be in IDLE and able to accept start.

Verification (WIDTH=8)
REQ-026 The bench SHALL cover: a=0x05, b=0x03, start pulsed at E0 -> busy E0..E7, done=1 after E8, difference=0x02, borrow=0.
REQ-027 The bench SHALL cover: a=0x03, b=0x05 -> difference=0xFE, borrow=1.
REQ-028 The bench SHALL cover: exhaustive 1-bit corner cases, namely a/b = 0x00/0x00, 0xFF/0x01 and 0x00/0xFF.
- 0x00/0x00 -> 0x00, borrow 0.
- 0xFF/0x01 -> 0xFE, borrow 0.
- 0x00/0xFF -> 0x01, borrow 1.
REQ-029 The bench SHALL cover: start re-pulsed at E3 with new operands -> ignored; the result equals the first operation's; done pulses exactly once at E8.
REQ-030 The bench SHALL cover: start held high continuously with operands 0x80/0x01 -> done every 9 cycles with difference=0x7F, borrow=0.
REQ-031 The bench SHALL cover: rst_n pulled low at E4 of an operation -> busy and done drop immediately, outputs read zero, no done pulse; the next start (0x10 - 0x01) yields 0x0F at E8 relative to its acceptance.
